// File: rtl/serial_adder_controller.sv
// Bit-serial adder: one full adder (two half adders) reused across all operand
// bits, LSB first, with a start/busy/done handshake and registered results.

module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

module serial_adder_controller #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] shift_a_r;
    logic [WIDTH-1:0] shift_b_r;
    logic [WIDTH-1:0] result_r;
    logic             carry_reg_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_out_r;

    logic             s1_s;
    logic             c1_s;
    logic             sum_bit_s;
    logic             c2_s;
    logic             carry_next_s;
    logic             last_bit_s;
    logic [WIDTH-1:0] result_next_s;

    half_adder u_ha1 (
        .a     (shift_a_r[0]),
        .b     (shift_b_r[0]),
        .sum   (s1_s),
        .carry (c1_s)
    );

    half_adder u_ha2 (
        .a     (s1_s),
        .b     (carry_reg_r),
        .sum   (sum_bit_s),
        .carry (c2_s)
    );

    assign carry_next_s = c1_s | c2_s;
    assign last_bit_s   = (count_r == LAST_BIT);

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
    always_comb begin
        result_next_s            = result_r >> 1;
        result_next_s[WIDTH-1]   = sum_bit_s;
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_ADD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ADD: begin
                if (last_bit_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ADD;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, bit-serial datapath and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_a_r   <= {WIDTH{1'b0}};
            shift_b_r   <= {WIDTH{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            carry_reg_r <= 1'b0;
            count_r     <= {CW{1'b0}};
            sum_r       <= {WIDTH{1'b0}};
            carry_out_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        shift_a_r   <= input_a;
                        shift_b_r   <= input_b;
                        carry_reg_r <= carry_in;
                        count_r     <= {CW{1'b0}};
                    end
                end
                ST_ADD: begin
                    shift_a_r   <= shift_a_r >> 1;
                    shift_b_r   <= shift_b_r >> 1;
                    result_r    <= result_next_s;
                    carry_reg_r <= carry_next_s;
                    count_r     <= count_r + CW'(1);
                    // Outputs only ever see a completed result.
                    if (last_bit_s) begin
                        sum_r       <= result_next_s;
                        carry_out_r <= carry_next_s;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state_r == ST_ADD);
    assign done  = (state_r == ST_DONE);
    assign sum   = sum_r;
    assign carry = carry_out_r;

endmodule

// File: tb/tb_serial_adder_controller.sv
// Scoreboard bench for serial_adder_controller at WIDTH = 8, 1 and 16.

module tb_serial_adder_controller;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, carry8;
    logic [7:0] a8 = 8'd0, b8 = 8'd0, sum8;
    logic       start1 = 1'b0, cin1 = 1'b0, busy1, done1, carry1;
    logic [0:0] a1 = 1'b0, b1 = 1'b0, sum1;
    logic        start16 = 1'b0, cin16 = 1'b0, busy16, done16, carry16;
    logic [15:0] a16 = 16'd0, b16 = 16'd0, sum16;

    logic [8:0]  q8[$];
    logic [1:0]  q1[$];
    logic [16:0] q16[$];
    logic [8:0]  last8 = 9'd0;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clock = ~clock;

    serial_adder_controller #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .input_a(a8), .input_b(b8),
        .carry_in(cin8), .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
    );

    serial_adder_controller #(.WIDTH(1)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .input_a(a1), .input_b(b1),
        .carry_in(cin1), .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
    );

    serial_adder_controller #(.WIDTH(16)) dut16 (
        .clock(clock), .reset(reset), .start(start16), .input_a(a16), .input_b(b16),
        .carry_in(cin16), .busy(busy16), .done(done16), .sum(sum16), .carry(carry16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge one edge after acceptance; waits for done and scores it.
    task automatic wait8(input bit hold, input bit abuse);
        int lat  = 1;
        int bcnt = 0;
        while (!done8 && lat < 30) begin
            check("hold8", {carry8, sum8}, last8);
            if (busy8) bcnt++;
            if (abuse && lat == 3) begin
                a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; start8 = 1'b1;
            end else if (!hold) begin
                start8 = 1'b0;
            end
            @(negedge clock);
            lat++;
        end
        check("lat8", lat, 9);
        check("busy_cycles8", bcnt, 8);
        if (q8.size() == 0) begin
            check("sb8_empty", 1, 0);
        end else begin
            logic [8:0] exp;
            exp = q8.pop_front();
            check("res8", {carry8, sum8}, exp);
            last8 = exp;
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input bit hold, input bit abuse);
        @(negedge clock);
        a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
        q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, cin});
        @(negedge clock);
        if (!hold) start8 = 1'b0;
        wait8(hold, abuse);
        @(negedge clock);
        check("done_clr8", {busy8, done8}, 2'b00);
        if (hold) begin
            @(negedge clock);
            check("restart8", busy8, 1'b1);
            q8.push_back({1'b0, a8} + {1'b0, b8} + {8'd0, cin8});
            start8 = 1'b0;
            wait8(1'b0, 1'b0);
            @(negedge clock);
            check("done_clr8b", {busy8, done8}, 2'b00);
        end else begin
            @(negedge clock);
            check("no_restart8", busy8, 1'b0);
        end
    endtask

    task automatic op1(input logic a, input logic b, input logic cin);
        int lat;
        @(negedge clock);
        a1 = a; b1 = b; cin1 = cin; start1 = 1'b1;
        q1.push_back({1'b0, a} + {1'b0, b} + {1'b0, cin});
        @(negedge clock);
        start1 = 1'b0;
        lat = 1;
        check("busy1", busy1, 1'b1);
        while (!done1 && lat < 10) begin
            @(negedge clock);
            lat++;
        end
        check("lat1", lat, 2);
        check("res1", {carry1, sum1}, q1.pop_front());
        @(negedge clock);
        check("done_clr1", {busy1, done1}, 2'b00);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin);
        int lat;
        @(negedge clock);
        a16 = a; b16 = b; cin16 = cin; start16 = 1'b1;
        q16.push_back({1'b0, a} + {1'b0, b} + {16'd0, cin});
        @(negedge clock);
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom);
        lat = 1;
        while (!done16 && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check("lat16", lat, 17);
        check("res16", {carry16, sum16}, q16.pop_front());
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst8", {busy8, done8, carry8, sum8}, 11'd0);
        check("rst1", {busy1, done1, carry1, sum1}, 4'd0);
        check("rst16", {busy16, done16, carry16, sum16}, 19'd0);
        reset = 1'b0;

        op8(8'h3C, 8'h5A, 1'b0, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        op8(8'h3C, 8'h5A, 1'b0, 1'b0, 1'b1);
        op8(8'h11, 8'h22, 1'b1, 1'b1, 1'b0);

        // Reset on the 4th ADD cycle discards the operation.
        @(negedge clock);
        a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clock);
        start8 = 1'b0;
        repeat (3) @(negedge clock);
        check("busy_pre_rst", busy8, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst8", {busy8, done8, carry8, sum8}, 11'd0);
        reset = 1'b0;
        last8 = 9'd0;
        op8(8'h01, 8'h02, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            op1(v[2], v[1], v[0]);
        end

        op16(16'hFFFF, 16'h0000, 1'b1);
        for (int i = 0; i < 200; i++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/serial_adder_controller.md
# serial_adder_controller

Bit-serial N-bit adder that time-shares one 1-bit full adder across all operand bits, least significant bit first. The full adder is two `half_adder` instances plus an OR of their carries. The controller latches the operands and sequences one bit per clock. It then presents a registered `WIDTH`-bit sum and carry-out with a start/busy/done handshake. It sits beside the combinational adders as the area-minimal, multi-cycle alternative.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range is 1 or more.
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request; sampled only in IDLE.
- `input_a`  in  WIDTH: operand A; captured on the accepting edge.
- `input_b`  in  WIDTH: operand B; captured on the accepting edge.
- `carry_in`  in  1: initial carry; captured on the accepting edge.
- `busy`  out  1: high while bits are being processed (ADD state).
- `done`  out  1: one-cycle pulse; result valid and newly updated.
- `sum`  out  WIDTH: registered result of the last completed operation.
- `carry`  out  1: registered carry-out of the last completed operation.

## Operation
- Datapath:
  - half_adder #1: (a_bit, b_bit) -> (s1, c1).
  - half_adder #2: (s1, carry_reg) -> (sum_bit, c2).
  - next carry_reg = c1 | c2.
- Internal state:
  - shift_a and shift_b, each WIDTH bits, shifting right; bit 0 is the current bit.
  - result shift register, WIDTH bits; sum_bit enters at the MSB and the register shifts right.
  - carry_reg, 1 bit.
  - bit counter, ceil(log2(WIDTH+1)) bits, minimum 1.
- States: IDLE, ADD, DONE.
- IDLE:
  - `start`=1 -> capture `input_a`, `input_b` and `carry_in`; clear the counter; go to ADD.
  - `start`=0 -> stay in IDLE.
- ADD, every edge:
  - compute one bit and shift it into the result register;
  - shift the operands;
  - update carry_reg;
  - increment the counter.
- ADD, on the edge where the counter equals WIDTH-1:
  - load `sum` with the final result, including the bit computed on that edge;
  - load `carry` with the next carry value;
  - go to DONE.
- DONE: go to IDLE on the next edge, unconditionally.
- `busy` is 1 in ADD only. `done` is 1 in DONE only. Both are decoded from registered state.
- `start` is ignored in ADD and DONE; it is not queued. Back-to-back operations need `start` held or re-asserted in IDLE.
- Changes on `input_a`, `input_b` or `carry_in` after capture have no effect on the running operation.
- `sum` and `carry` hold their value between completions. They never show partial results.
- Arithmetic: {`carry`, `sum`} = `input_a` + `input_b` + `carry_in`, exact, in WIDTH+1 bits.
- Reset, including mid-operation:
  - state -> IDLE;
  - `busy`=0, `done`=0, `sum`=0, `carry`=0;
  - counter, shift registers and carry_reg cleared;
  - the in-flight operation is discarded.
- If `reset` and `start` are high on the same edge, `reset` wins.

## Timing
- Accepting edge E0: `start`=1 in IDLE. `busy` rises after E0.
- Edges E1..E_WIDTH: one bit each.
- After E_WIDTH: `busy`=0, `done`=1, `sum`/`carry` updated.
- After E_(WIDTH+1): `done`=0, state is IDLE.
- Latency from accepting edge to `done` is WIDTH+1 edges. Minimum initiation interval is WIDTH+2 cycles.
- WIDTH=1: one ADD cycle; `done` is high after E2's predecessor E1 and cleared after E2.
- No combinational path from any input to any output.

## Test plan
- WIDTH=8, A=0x3C, B=0x5A, cin=0, 1-cycle start:
  - `busy` high exactly 8 cycles;
  - `done` high 1 cycle, 9 edges after acceptance;
  - `sum`=0x96, `carry`=0.
- WIDTH=8, A=0xFF, B=0x01, cin=0 -> `sum`=0x00, `carry`=1. Then A=0xFF, B=0xFF, cin=1 -> `sum`=0xFF, `carry`=1. Previous result holds until the second `done`.
- Operand and start abuse, during ADD:
  - change inputs to A=0x00, B=0x00 and pulse `start` -> result still 0x3C+0x5A = 0x96;
  - no second operation begins;
  - `start` held high through DONE starts a new operation only from IDLE.
- Reset mid-operation:
  - assert `reset` on the 4th ADD cycle -> next cycle `busy`=0, `done`=0, `sum`=0, `carry`=0;
  - a subsequent start with A=0x01, B=0x02 yields `sum`=0x03, `carry`=0.
- WIDTH=1: A=1, B=1, cin=0 -> `sum`=0, `carry`=1, `done` after 2 edges. WIDTH=16: randomized 200 operations, each checked against a reference `a+b+cin`.
